// File: rtl/round_pkg.sv
// round_pkg: shared constants for the rounding integer divider.
//   ROUND_WIDTH_DEFAULT : default operand/result width
//   ROUND_LAT           : operand-to-result latency in cycles
//                         (2 when ROUND_IN_REG_EN is defined, else 1)
//   DEN_ONE             : denominator reported for every valid result
package round_pkg;

  localparam int ROUND_WIDTH_DEFAULT = 32;

`ifdef ROUND_IN_REG_EN
  localparam int ROUND_LAT = 2;
`else
  localparam int ROUND_LAT = 1;
`endif

  localparam int DEN_ONE = 1;

endpackage

// File: rtl/round_div_stage.sv
// round_div_stage: one row of an unrolled restoring divider.
// Shifts the next numerator bit into the partial remainder and subtracts
// the denominator when it fits.
//   den      : divisor (WIDTH bits)
//   rem_in   : partial remainder from the previous row (always < den)
//   num_bit  : next numerator bit, MSB first
//   q_bit    : quotient bit produced by this row
//   rem_out  : partial remainder for the next row
module round_div_stage #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] den,
  input  logic [WIDTH-1:0] rem_in,
  input  logic             num_bit,
  output logic             q_bit,
  output logic [WIDTH-1:0] rem_out
);

  // One extra bit: the shifted remainder can reach 2*den-1, which may not
  // fit in WIDTH bits.
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  always_comb begin
    trial = {rem_in, num_bit};
    diff  = trial - {1'b0, den};
    if (trial >= {1'b0, den}) begin
      q_bit   = 1'b1;
      rem_out = diff[WIDTH-1:0];
    end else begin
      q_bit   = 1'b0;
      rem_out = trial[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/round_quotient.sv
// round_quotient: rounding integer divider for the rational datapath.
// Produces round(num/den) as the rational out_num/out_den with out_den = 1.
// Rounds up when the remainder reaches the truncated half-denominator, so
// den = 1 always adds one. Division by zero yields all ones over 0.
// Optional build macro ROUND_IN_REG_EN adds an input register (latency 2).
//   clk, rst          : clock, synchronous active-high reset
//   in_num, in_den    : operands, accepted every cycle
//   out_num, out_den  : registered result
//   rdy               : outputs hold a valid result
// Flow: there is no handshake; operands present before a clock edge always
// produce a result ROUND_LAT edges later, and rdy marks results that
// originate from operands accepted after reset was released.
module round_quotient
  import round_pkg::*;
#(
  parameter int WIDTH = ROUND_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_num,
  input  logic [WIDTH-1:0] in_den,
  output logic [WIDTH-1:0] out_num,
  output logic [WIDTH-1:0] out_den,
  output logic             rdy
);

  logic [WIDTH-1:0] op_num;
  logic [WIDTH-1:0] op_den;

`ifdef ROUND_IN_REG_EN
  logic [WIDTH-1:0] num_q;
  logic [WIDTH-1:0] den_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      num_q <= '0;
      den_q <= '0;
    end else begin
      num_q <= in_num;
      den_q <= in_den;
    end
  end

  assign op_num = num_q;
  assign op_den = den_q;
`else
  assign op_num = in_num;
  assign op_den = in_den;
`endif

  // Unrolled divider: row i consumes numerator bit WIDTH-1-i.
  logic [WIDTH-1:0] rem [0:WIDTH];
  logic [WIDTH-1:0] quo;

  assign rem[0] = '0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_row
    round_div_stage #(.WIDTH(WIDTH)) u_stage (
      .den     (op_den),
      .rem_in  (rem[i]),
      .num_bit (op_num[WIDTH-1-i]),
      .q_bit   (quo[WIDTH-1-i]),
      .rem_out (rem[i+1])
    );
  end

  logic             round_up;
  logic [WIDTH-1:0] res_num;
  logic [WIDTH-1:0] res_den;

  always_comb begin
    round_up = (rem[WIDTH] >= (op_den >> 1));
    res_num  = quo + {{(WIDTH-1){1'b0}}, round_up};
    res_den  = WIDTH'(DEN_ONE);
    // The divider output is meaningless for den = 0; override it.
    if (op_den == '0) begin
      res_num = '1;
      res_den = '0;
    end
  end

  // rdy pipeline: one bit per latency stage, filled with ones after reset.
  logic [ROUND_LAT-1:0] rdy_sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_num <= '0;
      out_den <= '0;
      rdy_sr  <= '0;
    end else begin
      out_num <= res_num;
      out_den <= res_den;
      rdy_sr  <= (rdy_sr << 1) | ROUND_LAT'(1);
    end
  end

  assign rdy = rdy_sr[ROUND_LAT-1];

endmodule

// File: tb/tb_round_quotient.sv
// tb_round_quotient: self-checking bench for round_quotient.
// Directed cases carry hand-derived expected values; random cases use a
// reference model computed from plain integer division. Expected results
// wait in a queue and are popped once ROUND_LAT edges have passed.
module tb_round_quotient;
  import round_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic [W-1:0] in_num;
  logic [W-1:0] in_den;
  logic [W-1:0] out_num;
  logic [W-1:0] out_den;
  logic         rdy;

  int n_checks = 0;
  int n_errors = 0;

  // Each entry is {expected out_num, expected out_den}.
  logic [2*W-1:0] exp_q[$];

  round_quotient #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_num  (in_num),
    .in_den  (in_den),
    .out_num (out_num),
    .out_den (out_den),
    .rdy     (rdy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [2*W-1:0] obs,
                       input logic [2*W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [2*W-1:0] ref_round(input logic [W-1:0] n,
                                               input logic [W-1:0] d);
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (d == 0) return {{W{1'b1}}, {W{1'b0}}};
    q = n / d;
    r = n % d;
    if (r >= d / 2) q = q + 1;  // wraps modulo 2^W
    return {q, W'(1)};
  endfunction

  // ---------------- drivers ----------------
  // Apply one operand pair, clock it, then check whatever result is due.
  task automatic step_exp(input logic [W-1:0] n, input logic [W-1:0] d,
                          input logic [2*W-1:0] exp, input string tag);
    in_num = n;
    in_den = d;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() >= ROUND_LAT) begin
      check({tag, "_data"}, {out_num, out_den}, exp_q.pop_front());
      check({tag, "_rdy"}, 64'(rdy), 64'd1);
    end else begin
      check({tag, "_rdy_low"}, 64'(rdy), 64'd0);
    end
  endtask

  task automatic step_rand(input logic [W-1:0] n, input logic [W-1:0] d);
    step_exp(n, d, ref_round(n, d), "rand");
  endtask

  // One reset edge with random operands; nothing in flight survives it.
  task automatic reset_cycle(input string tag);
    rst    = 1'b1;
    in_num = $urandom;
    in_den = $urandom;
    @(posedge clk);
    #1;
    check({tag, "_out"}, {out_num, out_den}, 64'd0);
    check({tag, "_rdy"}, 64'(rdy), 64'd0);
    exp_q.delete();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst    = 1'b1;
    in_num = 7;
    in_den = 2;
    @(negedge clk);

    // Reset held three cycles.
    for (int i = 0; i < 3; i++) begin
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("reset_out", {out_num, out_den}, 64'd0);
      check("reset_rdy", 64'(rdy), 64'd0);
    end
    rst = 1'b0;

    // Release with 7/2; hold it until the first result is due.
    for (int i = 0; i < ROUND_LAT; i++) step_exp(7, 2, {32'd4, 32'd1}, "first_7_2");

    // Back-to-back directed operands.
    step_exp(9,   4,   {32'd2, 32'd1}, "d_9_4");
    step_exp(10,  3,   {32'd4, 32'd1}, "d_10_3");
    step_exp(0,   7,   {32'd0, 32'd1}, "d_0_7");
    step_exp(999, 500, {32'd2, 32'd1}, "d_999_500");
    step_exp(5,   1,   {32'd6, 32'd1}, "d_5_1");
    step_exp(32'hFFFF_FFFF, 1, {32'd0, 32'd1}, "d_wrap");
    step_exp(123, 0,   {32'hFFFF_FFFF, 32'd0}, "d_div0");
    step_exp(20,  6,   {32'd3, 32'd1}, "d_20_6");
    step_exp(11,  2,   {32'd6, 32'd1}, "d_11_2");

    // Mid-stream reset with a result in flight.
    step_exp(100, 7, {32'd14, 32'd1}, "pre_rst");
    reset_cycle("mid_rst");
    for (int i = 0; i < ROUND_LAT; i++) step_exp(20, 6, {32'd3, 32'd1}, "post_rst");

    // Random sweep over the small-operand range.
    for (int i = 0; i < 10000; i++)
      step_rand($urandom_range(999, 1), $urandom_range(999, 1));

    // Full-range operands, including some zero and tiny denominators.
    for (int i = 0; i < 300; i++) begin
      logic [W-1:0] d;
      case ($urandom_range(3, 0))
        0:       d = 0;
        1:       d = $urandom_range(3, 1);
        default: d = $urandom;
      endcase
      step_rand($urandom, d);
    end

    // Drain the pipeline with extra operands so every queued result is checked.
    for (int i = 0; i < ROUND_LAT; i++)
      step_rand($urandom_range(999, 1), $urandom_range(999, 1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
